// File: rtl/priority_resolver_n.sv
// Parametrised PIC priority resolver: owns IRR/ISR/IMR, rotating priority,
// edge/level triggering, two-pulse INTA sequencer and automatic EOI.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   IR[N-1:0]                   request lines (already synchronous)
//   LTIM                        1 = level-triggered, 0 = edge-triggered
//   AEOI                        automatic EOI on the second INTA
//   IM[N-1:0], IM_WE            mask write data / strobe
//   INTA                        acknowledge strobe (one cycle per pulse)
//   CMD_VALID, CMD[2:0]         command strobe, {R, SL, EOI}
//   CMD_LVL[VW-1:0]             level operand for specific commands
//   INT                         interrupt request to the CPU
//   INT_VEC, VEC_VALID, SPUR    acknowledged level, valid pulse, spurious
//   IRR, ISR, IMR               register contents
module priority_resolver_n #(
    parameter int N  = 8,
    parameter int VW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  IR,
    input  logic          LTIM,
    input  logic          AEOI,
    input  logic [N-1:0]  IM,
    input  logic          IM_WE,
    input  logic          INTA,
    input  logic          CMD_VALID,
    input  logic [2:0]    CMD,
    input  logic [VW-1:0] CMD_LVL,
    output logic          INT,
    output logic [VW-1:0] INT_VEC,
    output logic          VEC_VALID,
    output logic          SPUR,
    output logic [N-1:0]  IRR,
    output logic [N-1:0]  ISR,
    output logic [N-1:0]  IMR
);

    typedef enum logic {S_IDLE, S_ACK1} state_t;

    state_t        state, state_n;
    logic [N-1:0]  irr, irr_n;
    logic [N-1:0]  isr, isr_n;
    logic [N-1:0]  imr, imr_n;
    logic [N-1:0]  ir_prev;
    logic [VW-1:0] lp, lp_n;
    logic          rot, rot_n;
    logic [VW-1:0] w, w_n;
    logic          sflag, sflag_n;
    logic [VW-1:0] vec, vec_n;
    logic          vv, vv_n;
    logic          sp, sp_n;

    // Returns {found, index} of the highest-priority set bit. Priority
    // starts at lp+1 and wraps; the scan runs lowest to highest so the
    // highest-priority hit is the last one written.
    function automatic logic [VW:0] pick(input logic [N-1:0]  v,
                                         input logic [VW-1:0] l);
        logic [VW:0]   r;
        logic [VW-1:0] idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = l + VW'(k + 1);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [VW:0]   win, hi;
    logic          w_found, h_found;
    logic [VW-1:0] w_idx, h_idx;
    logic [VW-1:0] w_rank, h_rank;

    assign win     = pick(irr & ~imr, lp);
    assign hi      = pick(isr, lp);
    assign w_found = win[VW];
    assign w_idx   = win[VW-1:0];
    assign h_found = hi[VW];
    assign h_idx   = hi[VW-1:0];

    // Distance from the top of the priority order; smaller is higher.
    assign w_rank = w_idx - lp - VW'(1);
    assign h_rank = h_idx - lp - VW'(1);

    assign INT = (state == S_IDLE) && w_found &&
                 (!h_found || (w_rank < h_rank));

    always_comb begin
        state_n = state;
        irr_n   = LTIM ? IR : (irr | (IR & ~ir_prev));
        isr_n   = isr;
        imr_n   = IM_WE ? IM : imr;
        lp_n    = lp;
        rot_n   = rot;
        w_n     = w;
        sflag_n = sflag;
        vec_n   = vec;
        vv_n    = 1'b0;
        sp_n    = 1'b0;

        // Command clears land before the INTA set below.
        if (CMD_VALID) begin
            case (CMD)
                3'b001: if (h_found) isr_n[h_idx] = 1'b0;
                3'b011: isr_n[CMD_LVL] = 1'b0;
                3'b101: if (h_found) begin
                    isr_n[h_idx] = 1'b0;
                    lp_n = h_idx;
                end
                3'b111: begin
                    isr_n[CMD_LVL] = 1'b0;
                    lp_n = CMD_LVL;
                end
                3'b110: lp_n = CMD_LVL;
                3'b100: rot_n = 1'b1;
                3'b000: rot_n = 1'b0;
                default: ;
            endcase
        end

        if (INTA) begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_ACK1;
                    if (w_found) begin
                        isr_n[w_idx] = 1'b1;
                        irr_n[w_idx] = 1'b0;
                        w_n     = w_idx;
                        sflag_n = 1'b0;
                    end else begin
                        w_n     = '1;
                        sflag_n = 1'b1;
                    end
                end
                S_ACK1: begin
                    state_n = S_IDLE;
                    vec_n   = w;
                    vv_n    = 1'b1;
                    sp_n    = sflag;
                    if (AEOI && !sflag) begin
                        isr_n[w] = 1'b0;
                        if (rot) lp_n = w;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            irr     <= '0;
            isr     <= '0;
            imr     <= '0;
            ir_prev <= '0;
            lp      <= '1;
            rot     <= 1'b0;
            w       <= '0;
            sflag   <= 1'b0;
            vec     <= '0;
            vv      <= 1'b0;
            sp      <= 1'b0;
        end else begin
            state   <= state_n;
            irr     <= irr_n;
            isr     <= isr_n;
            imr     <= imr_n;
            ir_prev <= IR;
            lp      <= lp_n;
            rot     <= rot_n;
            w       <= w_n;
            sflag   <= sflag_n;
            vec     <= vec_n;
            vv      <= vv_n;
            sp      <= sp_n;
        end
    end

    assign INT_VEC   = vec;
    assign VEC_VALID = vv;
    assign SPUR      = sp;
    assign IRR       = irr;
    assign ISR       = isr;
    assign IMR       = imr;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Bench for priority_resolver_n: directed scenarios plus random traffic,
// checked against a behavioural model (N=8) and constants (N=16).
module tb_priority_resolver_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir, im;
    logic       ltim, aeoi, im_we, inta, cmd_valid;
    logic [2:0] cmd, cmd_lvl;
    logic       irq, vv, spur;
    logic [2:0] vec;
    logic [7:0] irr, isr, imr;

    logic        rst16, inta16, cmdv16;
    logic [15:0] ir16, im16, irr16, isr16, imr16;
    logic [2:0]  cmd16;
    logic [3:0]  lvl16, vec16;
    logic        irq16, vv16, spur16;
    logic        zero = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    priority_resolver_n #(.N(8)) u8 (
        .CLK(clk), .RST(rst), .IR(ir), .LTIM(ltim), .AEOI(aeoi),
        .IM(im), .IM_WE(im_we), .INTA(inta), .CMD_VALID(cmd_valid),
        .CMD(cmd), .CMD_LVL(cmd_lvl), .INT(irq), .INT_VEC(vec),
        .VEC_VALID(vv), .SPUR(spur), .IRR(irr), .ISR(isr), .IMR(imr)
    );

    priority_resolver_n #(.N(16)) u16 (
        .CLK(clk), .RST(rst16), .IR(ir16), .LTIM(zero), .AEOI(zero),
        .IM(im16), .IM_WE(zero), .INTA(inta16), .CMD_VALID(cmdv16),
        .CMD(cmd16), .CMD_LVL(lvl16), .INT(irq16), .INT_VEC(vec16),
        .VEC_VALID(vv16), .SPUR(spur16), .IRR(irr16), .ISR(isr16),
        .IMR(imr16)
    );

    // Behavioural model of the N=8 instance.
    logic [7:0] m_irr, m_isr, m_imr, m_prev;
    int m_lp, m_w, m_vec;
    bit m_rot, m_ack, m_sf, m_vv, m_sp;

    function automatic int rnk(int i);
        return (i - m_lp - 1 + 16) % 8;
    endfunction

    function automatic int top(logic [7:0] v);
        int b;
        b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rnk(i) < rnk(b))) b = i;
        return b;
    endfunction

    function automatic bit m_int();
        int w, h;
        w = top(m_irr & ~m_imr);
        h = top(m_isr);
        return !m_ack && w >= 0 && (h < 0 || rnk(w) < rnk(h));
    endfunction

    task automatic model_step();
        int w, h, nl;
        logic [7:0] ni, ns;
        bit nr;
        if (rst) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_prev = 0;
            m_lp = 7; m_rot = 0; m_ack = 0; m_sf = 0;
            m_w = 0; m_vec = 0; m_vv = 0; m_sp = 0;
            return;
        end
        w  = top(m_irr & ~m_imr);
        h  = top(m_isr);
        ni = ltim ? ir : (m_irr | (ir & ~m_prev));
        ns = m_isr;
        nl = m_lp;
        nr = m_rot;
        m_vv = 0;
        m_sp = 0;
        if (cmd_valid) begin
            case (cmd)
                3'b001: if (h >= 0) ns[h] = 1'b0;
                3'b011: ns[cmd_lvl] = 1'b0;
                3'b101: if (h >= 0) begin ns[h] = 1'b0; nl = h; end
                3'b111: begin ns[cmd_lvl] = 1'b0; nl = cmd_lvl; end
                3'b110: nl = cmd_lvl;
                3'b100: nr = 1;
                3'b000: nr = 0;
                default: ;
            endcase
        end
        if (inta && !m_ack) begin
            if (w >= 0) begin
                ns[w] = 1'b1; ni[w] = 1'b0; m_w = w; m_sf = 0;
            end else begin
                m_w = 7; m_sf = 1;
            end
            m_ack = 1;
        end else if (inta) begin
            m_vec = m_w; m_vv = 1; m_sp = m_sf;
            if (aeoi && !m_sf) begin
                ns[m_w] = 1'b0;
                if (m_rot) nl = m_w;
            end
            m_ack = 0;
        end
        if (im_we) m_imr = im;
        m_prev = ir;
        m_irr = ni; m_isr = ns; m_lp = nl; m_rot = nr;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("int", 32'(irq), 32'(m_int()));
        chk("irr", 32'(irr), 32'(m_irr));
        chk("isr", 32'(isr), 32'(m_isr));
        chk("imr", 32'(imr), 32'(m_imr));
        chk("vec_valid", 32'(vv), 32'(m_vv));
        chk("spur", 32'(spur), 32'(m_sp));
        chk("int_vec", 32'(vec), 32'(m_vec));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        inta = 0; cmd_valid = 0; im_we = 0;
        inta16 = 0; cmdv16 = 0;
    endtask

    task automatic ack2(int exp);
        inta = 1; tick();
        inta = 1; tick();
        chk("ack_vec", 32'(vec), 32'(exp));
        chk("ack_valid", 32'(vv), 32'd1);
    endtask

    task automatic do_cmd(logic [2:0] c, logic [2:0] l);
        cmd_valid = 1; cmd = c; cmd_lvl = l; tick();
    endtask

    task automatic ack16(int exp);
        inta16 = 1; tick();
        inta16 = 1; tick();
        chk("n16_vec", 32'(vec16), 32'(exp));
        chk("n16_valid", 32'(vv16), 32'd1);
    endtask

    initial begin
        rst = 1; ir = 0; im = 0; ltim = 0; aeoi = 0; im_we = 0;
        inta = 0; cmd_valid = 0; cmd = 0; cmd_lvl = 0;
        rst16 = 1; inta16 = 0; cmdv16 = 0; ir16 = 0; im16 = 0;
        cmd16 = 0; lvl16 = 0;
        tick();
        chk("rst_int", 32'(irq), 0);
        chk("rst_isr", 32'(isr), 0);
        chk("rst_vec", 32'(vec), 0);
        rst = 0; rst16 = 0;
        tick();

        // Fixed priority and non-specific EOI
        ir = 8'b1000_0001; tick();
        chk("req_int", 32'(irq), 1);
        ack2(0);
        chk("fp_isr", 32'(isr), 32'h01);
        chk("fp_irr", 32'(irr), 32'h80);
        do_cmd(3'b001, 0);
        chk("nseoi_int", 32'(irq), 1);
        ack2(7);
        do_cmd(3'b001, 0);
        chk("nseoi_isr", 32'(isr), 0);
        chk("nseoi_int0", 32'(irq), 0);

        // Rotation
        ir = 0; do_cmd(3'b110, 3);
        ir = 8'b0011_0001; tick();
        ack2(4);
        do_cmd(3'b101, 0);
        ack2(5);
        do_cmd(3'b101, 0);
        ack2(0);
        do_cmd(3'b011, 0);
        chk("seoi_isr", 32'(isr), 0);
        ir = 0; do_cmd(3'b110, 7);

        // Masking
        im = 8'h01; im_we = 1; tick();
        ir = 8'h01; tick();
        chk("mask_int", 32'(irq), 0);
        ir = 8'h03; tick();
        ack2(1);
        do_cmd(3'b001, 0);
        im = 0; im_we = 1; tick();
        ack2(0);
        do_cmd(3'b001, 0);
        ir = 0; tick();

        // Nesting
        ir = 8'h04; tick();
        ack2(2);
        ir = 8'h24; tick();
        chk("nest_lo", 32'(irq), 0);
        ir = 8'h25; tick();
        chk("nest_hi", 32'(irq), 1);
        ack2(0);
        do_cmd(3'b001, 0);
        do_cmd(3'b001, 0);
        ack2(5);
        do_cmd(3'b001, 0);
        ir = 0; tick();

        // AEOI with rotation
        aeoi = 1; do_cmd(3'b100, 0);
        ir = 8'h08; tick();
        ack2(3);
        chk("aeoi_isr", 32'(isr), 0);
        ir = 0; tick();
        ir = 8'h11; tick();
        ack2(4);
        chk("aeoi_isr2", 32'(isr), 0);
        aeoi = 0; do_cmd(3'b000, 0);
        do_cmd(3'b110, 7);
        ack2(0);
        do_cmd(3'b001, 0);
        ir = 0; tick();

        // Edge versus level triggering
        ir = 8'h02; tick();
        ack2(1);
        do_cmd(3'b001, 0);
        chk("edge_int", 32'(irq), 0);
        chk("edge_irr", 32'(irr), 0);
        ltim = 1; tick();
        ack2(1);
        do_cmd(3'b001, 0);
        chk("lvl_int", 32'(irq), 1);
        ir = 0; tick();
        ltim = 0; tick();

        // Spurious acknowledge
        ir = 8'h08; tick();
        ack2(3);
        ir = 0; tick();
        ack2(7);
        chk("spur", 32'(spur), 1);
        chk("spur_isr", 32'(isr), 32'h08);
        do_cmd(3'b001, 0);

        // Reset between the two INTA pulses
        ir = 8'h02; tick();
        inta = 1; tick();
        ir = 0; rst = 1; tick();
        chk("rst_vv", 32'(vv), 0);
        chk("rst_irr", 32'(irr), 0);
        chk("rst_isr2", 32'(isr), 0);
        chk("rst_int2", 32'(irq), 0);
        rst = 0; tick();

        // N=16 wrap-around
        cmdv16 = 1; cmd16 = 3'b110; lvl16 = 9; tick();
        ir16 = 16'h8200; tick();
        chk("n16_int", 32'(irq16), 1);
        ack16(15);
        cmdv16 = 1; cmd16 = 3'b001; tick();
        ack16(9);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            ir = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ltim = ~ltim;
            aeoi = 1'($urandom_range(0, 1));
            im_we = ($urandom_range(0, 7) == 0);
            im = 8'($urandom) & 8'($urandom);
            inta = ($urandom_range(0, 2) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd = 3'($urandom);
            cmd_lvl = 3'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_resolver_n.md
# priority_resolver_n

Clocked, parametrised priority resolver for the PIC datapath. It generalises the fixed 8-input resolver to N request lines and adds edge/level triggering, an internal two-pulse INTA sequencer, automatic EOI, and programmable/automatic priority rotation. It sits between the IR pins and the control logic. It owns IRR, ISR and IMR, and hands the control logic the acknowledged level for vector formation.

## Interface
- N, 8: number of interrupt lines; power of 2, 4..32.
- VW, $clog2(N): level/vector width (derived).
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IR  in  N  raw request lines, already synchronous to CLK.
- LTIM  in  1  1 = level-triggered, 0 = edge-triggered.
- AEOI  in  1  1 = automatic EOI on second INTA.
- IM  in  N  mask write data.
- IM_WE  in  1  load IMR from IM this cycle.
- INTA  in  1  acknowledge strobe, one CLK cycle per CPU INTA pulse.
- CMD_VALID  in  1  OCW2-style command strobe.
- CMD  in  3  {R, SL, EOI}.
- CMD_LVL  in  VW  level operand for SL commands.
- INT  out  1  interrupt request to CPU.
- INT_VEC  out  VW  acknowledged level.
- VEC_VALID  out  1  one-cycle pulse; INT_VEC valid.
- SPUR  out  1  one-cycle pulse with VEC_VALID when the acknowledge was spurious.
- IRR, ISR, IMR  out  N each  current register contents.

## Operation
- Reset: IRR=ISR=IMR=0, IR_prev=0, LP=N-1 (IR0 highest), rotate-in-AEOI flag=0, state IDLE. INT=0, INT_VEC=0, VEC_VALID=0, SPUR=0.
- Edge mode: IRR[i] sets when IR[i]=1 and IR_prev[i]=0. It stays set until acknowledged; re-arming needs IR low for ≥1 cycle.
- Level mode: IRR[i]=IR[i] each cycle, except for the bit cleared by acknowledge that cycle.
- Priority order is (LP+1) mod N, highest first, down to LP, lowest; it wraps modulo N.
- Winner is the highest-priority bit of IRR & ~IMR.
- INT=1 in IDLE when a winner exists and has strictly higher priority than the highest ISR bit, or ISR=0. INT is forced 0 outside IDLE.
- FSM IDLE -> ACK1 on INTA:
  - With a winner W: ISR[W] set, IRR[W] cleared, W latched.
  - With no winner (spurious): W=N-1, ISR/IRR unchanged, spurious flag latched.
- FSM ACK1 -> IDLE on INTA:
  - INT_VEC=W, VEC_VALID=1 for one cycle; SPUR=1 if the spurious flag is set.
  - If AEOI and not spurious: ISR[W] cleared; LP=W if the rotate flag is set.
- INTA in ACK1 always completes the sequence. There is no timeout.
- Commands, decoded on CMD_VALID:
  - 001: non-specific EOI; clear the highest-priority ISR bit.
  - 011: specific EOI; clear ISR[CMD_LVL].
  - 101: rotate on non-specific EOI; clear the highest ISR bit H, LP=H.
  - 111: rotate on specific EOI; clear ISR[CMD_LVL], LP=CMD_LVL.
  - 110: set priority; LP=CMD_LVL.
  - 100: set the rotate-in-AEOI flag.
  - 000: clear the rotate-in-AEOI flag.
  - 010: no-op.
- A non-specific EOI with ISR=0 is a no-op; LP is unchanged.
- A specific EOI on a clear bit is a no-op, but LP still updates for 111.
- Simultaneous events:
  - EOI and INTA in the same cycle: both are evaluated on the pre-edge ISR/LP. Command clears are applied first, then the INTA set.
  - An LP change and INTA in the same cycle: the winner uses the old LP.
  - IM_WE: the new mask affects resolution from the next cycle.
- RST mid-sequence: returns to IDLE, all state as at reset, and no VEC_VALID is emitted.

## Timing
- IR rise before edge k: IRR set at edge k; INT high after edge k (combinational from registered state).
- First INTA sampled at edge m: ISR/IRR update at m; INT low after m.
- Second INTA at edge p: VEC_VALID/INT_VEC registered at p, high for exactly cycle p..p+1.
- AEOI clear also happens at p.
- EOI command at edge e: ISR updated at e. A pending request raises INT after e, with zero-cycle turnaround.
- INT_VEC holds its last value between pulses.

## Test plan
- Fixed priority and NS-EOI (N=8):
  - IR=10000001, INTA×2 -> VEC 0, ISR=00000001, IRR=10000000.
  - CMD 001 -> ISR=0, INT=1; INTA×2 -> VEC 7.
  - CMD 001 -> ISR=0, INT=0.
- Rotation:
  - CMD 110 with LVL=3, IR=00110001 -> VEC 4.
  - CMD 101 -> LP=4; next INTA×2 -> VEC 5.
  - CMD 101 -> next VEC 0.
  - CMD 011 with LVL=0 -> ISR=0.
- Masking and nesting:
  - IM=00000001, IR=00000001 -> INT=0; IR=00000011 -> VEC 1.
  - With ISR[2] set: edge on IR5 -> INT=0; edge on IR0 -> INT=1.
- AEOI and triggering:
  - AEOI=1, rotate flag set: after the sequence ISR=0 and LP=W.
  - Edge mode, IR held high -> no re-request after EOI.
  - LTIM=1 -> re-request after EOI.
- Spurious and reset:
  - INTA with no request -> VEC N-1, SPUR=1, ISR unchanged.
  - RST between INTAs -> no VEC_VALID, all outputs at reset values.
- N=16: requests on IR15 and IR9 with LP=9 -> VEC 15 first (wrap), then 9.
